// File: rtl/gate_truth_table_probe.sv
`default_nettype none
// ============================================================================
// gate_truth_table_probe : sweeps a 2-input gate through 00..11, builds its
// truth table and decodes the gate identity.             Rev 1.0
// ============================================================================
module gate_truth_table_probe #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_dut_a,
  output logic       o_dut_b,
  input  logic       i_dut_out,
  output logic       o_done,
  output logic [3:0] o_truth_table,
  output logic [2:0] o_gate_id,
  output logic       o_valid_id
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_RUN    = 2'd1;
  localparam logic [1:0] c_FINISH = 2'd2;
  localparam logic [3:0] c_SETTLE = 4'(SETTLE_CYCLES);

  logic [1:0] r_state;
  logic [1:0] r_idx;
  logic [3:0] r_cnt;
  logic       r_busy;
  logic       r_a;
  logic       r_b;
  logic       r_done;
  logic [3:0] r_tt;
  logic [2:0] r_gate_id;
  logic       r_valid;
  logic [2:0] w_gate_id;

  // Bit i of the pattern is the output seen with {a,b} = i.
  always_comb begin
    w_gate_id = 3'd0;
    case (r_tt)
      4'b1000: w_gate_id = 3'd1;
      4'b1110: w_gate_id = 3'd2;
      4'b0111: w_gate_id = 3'd3;
      4'b0001: w_gate_id = 3'd4;
      4'b0110: w_gate_id = 3'd5;
      4'b1001: w_gate_id = 3'd6;
      4'b0011: w_gate_id = 3'd7;
      default: w_gate_id = 3'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_idx     <= 2'd0;
      r_cnt     <= 4'd0;
      r_busy    <= 1'b0;
      r_a       <= 1'b0;
      r_b       <= 1'b0;
      r_done    <= 1'b0;
      r_tt      <= 4'b0;
      r_gate_id <= 3'd0;
      r_valid   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          r_a <= 1'b0;
          r_b <= 1'b0;
          if (i_start) begin
            r_state <= c_RUN;
            r_idx   <= 2'd0;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
          end
        end
        c_RUN: begin
          if (r_cnt != c_SETTLE) begin
            r_cnt <= r_cnt + 4'd1;
          end else begin
            r_tt[r_idx] <= i_dut_out;
            if (r_idx == 2'd3) begin
              r_state <= c_FINISH;
            end else begin
              r_idx        <= r_idx + 2'd1;
              r_cnt        <= 4'd0;
              {r_a, r_b}   <= r_idx + 2'd1;
            end
          end
        end
        c_FINISH: begin
          r_gate_id <= w_gate_id;
          r_done    <= 1'b1;
          r_valid   <= 1'b1;
          r_busy    <= 1'b0;
          r_a       <= 1'b0;
          r_b       <= 1'b0;
          r_state   <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_dut_a       = r_a;
  assign o_dut_b       = r_b;
  assign o_done        = r_done;
  assign o_truth_table = r_tt;
  assign o_gate_id     = r_gate_id;
  assign o_valid_id    = r_valid;

endmodule
`default_nettype wire
